// File: rtl/cache_fill_pkg.sv
`timescale 1ns/1ps
// cache_fill_pkg: shared types and constants for the cache line-fill engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the default line geometry, the Wishbone byte-select constant, the
// fill FSM state encoding and the address-slice positions for the default
// 8-word line.
package cache_fill_pkg;

    // Default line geometry: 8 words of 4 bytes = 32-byte lines.
    localparam int DEF_LINE_WORDS = 8;
    localparam int DEF_IDX_W      = $clog2(DEF_LINE_WORDS);

    // Width of the byte offset inside one 32-bit word.
    localparam int BYTE_OFS_W = 2;

    // Every read to exmem is a full 32-bit word.
    localparam logic [3:0] WB_SEL_ALL = 4'hF;

    // Address slices for the default line size: [31:5] line, [4:2] word.
    localparam int LINE_ADR_MSB = 31;
    localparam int LINE_ADR_LSB = DEF_IDX_W + BYTE_OFS_W;
    localparam int WORD_ADR_MSB = LINE_ADR_LSB - 1;
    localparam int WORD_ADR_LSB = BYTE_OFS_W;

    // Fill FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } fill_state_t;

endpackage

// File: rtl/fill_watchdog.sv
`timescale 1ns/1ps
// fill_watchdog: per-beat acknowledge timeout counter for the line filler.
// Latency: expire is combinational from the count; count updates each clock.
// Backpressure: none; counts while enabled and saturates at its last value.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        clear the count (held while the engine is not waiting on ack)
//   en          count this cycle (engine is waiting on ack)
//   expire      en && count has reached TIMEOUT_CYC-1
// TIMEOUT_CYC == 0 removes the counter entirely and expire is tied low.
module fill_watchdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            logic unused_wd;
            assign unused_wd = ^{clk, rst_n, load, en};
            assign expire    = 1'b0;
        end else begin : g_on
            localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

            logic [CNT_W-1:0] cnt_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else if (load) begin
                    cnt_q <= '0;
                end else if (en && (cnt_q != LAST)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            // The count reaches LAST on the TIMEOUT_CYC-th waiting cycle, so
            // the engine gives up after exactly TIMEOUT_CYC strobe cycles.
            assign expire = en && (cnt_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/cache_line_filler.sv
`timescale 1ns/1ps
// cache_line_filler: fetches one cache line from exmem as single-beat classic-WB reads.
// Latency: first m_stb_o one cycle after fill_req_i; each beat costs ack latency + 1.
// Backpressure: waits on m_ack_i per beat; watchdog aborts a stuck beat with fill_err_o.
//
// Optional feature macro: CRITICAL_WORD_FIRST_EN
//   defined   - the fill starts at the requested word fill_adr_i[4:2] and wraps.
//   undefined - the fill always starts at word 0; fill_adr_i[4:2] is ignored.
//
// Ports:
//   wb_clk_i, wb_rst_i         clock, asynchronous active-low reset
//   fill_req_i, fill_adr_i     start a fill of the line holding fill_adr_i (IDLE only)
//   fill_abort_i               drop the current fill, no done/err pulse
//   fill_busy_o                engine not idle
//   fill_vld_o/idx_o/dat_o     one-cycle strobe per returned word with its line index
//   fill_done_o, fill_err_o    end-of-fill pulse; err marks a watchdog timeout
//   m_cyc_o..m_dat_i           classic Wishbone read master towards exmem
module cache_line_filler
    import cache_fill_pkg::*;
#(
    parameter  int LINE_WORDS  = DEF_LINE_WORDS,
    parameter  int TIMEOUT_CYC = 255,
    localparam int IDX_W       = $clog2(LINE_WORDS)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             fill_req_i,
    input  logic [31:0]      fill_adr_i,
    input  logic             fill_abort_i,
    output logic             fill_busy_o,
    output logic             fill_vld_o,
    output logic [IDX_W-1:0] fill_idx_o,
    output logic [31:0]      fill_dat_o,
    output logic             fill_done_o,
    output logic             fill_err_o,
    output logic             m_cyc_o,
    output logic             m_stb_o,
    output logic             m_we_o,
    output logic [3:0]       m_sel_o,
    output logic [31:0]      m_adr_o,
    input  logic             m_ack_i,
    input  logic [31:0]      m_dat_i
);

    // Lowest line-address bit for this line size.
    localparam int LINE_LSB = IDX_W + BYTE_OFS_W;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

    fill_state_t         state_q;
    logic [31:LINE_LSB]  line_q;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    beat_cnt_q;
    logic                busy_q;
    logic                cyc_q;
    logic                stb_q;
    logic                vld_q;
    logic [IDX_W-1:0]    vld_idx_q;
    logic [31:0]         dat_q;
    logic                done_q;
    logic                err_q;
    logic [IDX_W-1:0]    start_idx;
    logic                wdog_expire;

    // Byte offset is never used; the word offset only matters with CWF.
    logic unused_adr;
    assign unused_adr = ^fill_adr_i[LINE_LSB-1:0];

`ifdef CRITICAL_WORD_FIRST_EN
    assign start_idx = fill_adr_i[LINE_LSB-1:BYTE_OFS_W];
`else
    assign start_idx = '0;
`endif

    // The watchdog is held clear outside REQ, so every beat (and every
    // re-entry from GAP) starts with a fresh count.
    fill_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_i),
        .load   (state_q != ST_REQ),
        .en     (state_q == ST_REQ),
        .expire (wdog_expire)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q    <= ST_IDLE;
            line_q     <= '0;
            idx_q      <= '0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            vld_q      <= 1'b0;
            vld_idx_q  <= '0;
            dat_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;

            // Abort beats everything, including an ack in the same cycle:
            // that word is dropped and no end-of-fill pulse is produced.
            if (fill_abort_i && (state_q != ST_IDLE)) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                cyc_q   <= 1'b0;
                stb_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (fill_req_i) begin
                            state_q    <= ST_REQ;
                            line_q     <= fill_adr_i[31:LINE_LSB];
                            idx_q      <= start_idx;
                            beat_cnt_q <= '0;
                            busy_q     <= 1'b1;
                            cyc_q      <= 1'b1;
                            stb_q      <= 1'b1;
                        end
                    end

                    ST_REQ: begin
                        if (m_ack_i) begin
                            vld_q     <= 1'b1;
                            vld_idx_q <= idx_q;
                            dat_q     <= m_dat_i;
                            // Power-of-two line: the natural overflow wraps
                            // the index inside the line.
                            idx_q     <= idx_q + 1'b1;
                            stb_q     <= 1'b0;
                            if (beat_cnt_q == LAST_BEAT) begin
                                state_q <= ST_DONE;
                                cyc_q   <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q    <= ST_GAP;
                                beat_cnt_q <= beat_cnt_q + 1'b1;
                            end
                        end else if (wdog_expire) begin
                            state_q <= ST_DONE;
                            cyc_q   <= 1'b0;
                            stb_q   <= 1'b0;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end

                    // One idle-strobe cycle with the bus still owned, so each
                    // classic-WB beat is a distinct strobe.
                    ST_GAP: begin
                        state_q <= ST_REQ;
                        stb_q   <= 1'b1;
                    end

                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end

                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign fill_busy_o = busy_q;
    assign fill_vld_o  = vld_q;
    assign fill_idx_o  = vld_idx_q;
    assign fill_dat_o  = dat_q;
    assign fill_done_o = done_q;
    assign fill_err_o  = err_q;

    assign m_cyc_o = cyc_q;
    assign m_stb_o = stb_q;
    assign m_we_o  = 1'b0;
    assign m_sel_o = WB_SEL_ALL;
    // The index field wraps, so the address can never leave the line.
    assign m_adr_o = {line_q, idx_q, {BYTE_OFS_W{1'b0}}};

endmodule

// File: tb/tb_cache_line_filler.sv
`timescale 1ns/1ps
// tb_cache_line_filler: directed bench for the cache line-fill engine.
// Drives a classic-WB slave with programmable ack latency and checks word
// order, addresses, data, timing of done/err, abort and reset behaviour.
module tb_cache_line_filler;

    localparam int LW = 8;
    localparam int TO = 4;
`ifdef CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fill_req;
    logic        fill_abort;
    logic [31:0] fill_adr;
    logic        fill_busy;
    logic        fill_vld;
    logic [2:0]  fill_idx;
    logic [31:0] fill_dat;
    logic        fill_done;
    logic        fill_err;
    logic        m_cyc;
    logic        m_stb;
    logic        m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_adr;
    logic        m_ack;
    logic [31:0] m_dat;

    always #5 clk = ~clk;

    cache_line_filler #(
        .LINE_WORDS  (LW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst_n),
        .fill_req_i   (fill_req),
        .fill_adr_i   (fill_adr),
        .fill_abort_i (fill_abort),
        .fill_busy_o  (fill_busy),
        .fill_vld_o   (fill_vld),
        .fill_idx_o   (fill_idx),
        .fill_dat_o   (fill_dat),
        .fill_done_o  (fill_done),
        .fill_err_o   (fill_err),
        .m_cyc_o      (m_cyc),
        .m_stb_o      (m_stb),
        .m_we_o       (m_we),
        .m_sel_o      (m_sel),
        .m_adr_o      (m_adr),
        .m_ack_i      (m_ack),
        .m_dat_i      (m_dat)
    );

    // ---------------- exmem slave model ----------------
    // ack_lat = number of strobe cycles up to and including the ack cycle
    // (1 = zero-wait, ack in the first strobe cycle).
    int ack_lat = 1;
    bit ack_en  = 1'b1;
    int stb_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                stb_cnt <= 0;
        else if (m_stb && !m_ack)  stb_cnt <= stb_cnt + 1;
        else                       stb_cnt <= 0;
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    assign m_ack = m_cyc && m_stb && ack_en && (stb_cnt == ack_lat - 1);
    assign m_dat = word_of(m_adr);

    // ---------------- monitors ----------------
    int edge_n = 0;
    int req_edge = -1;
    int done_edge = -1;
    int err_edge = -1;
    int idle_edge = -1;
    int done_n = 0;
    int err_n = 0;
    logic [31:0] adr_log[$];
    logic [31:0] dat_log[$];
    logic [2:0]  idx_log[$];

    // Edge counter; also timestamps the edge at which a fill is accepted.
    initial forever begin
        @(posedge clk);
        edge_n++;
        if (fill_req && !fill_busy && rst_n) req_edge = edge_n;
    end

    initial begin : mon_neg
        bit busy_d;
        busy_d = 1'b0;
        forever begin
            @(negedge clk);
            if (m_stb && m_ack) adr_log.push_back(m_adr);
            if (fill_vld) begin
                idx_log.push_back(fill_idx);
                dat_log.push_back(fill_dat);
            end
            if (fill_done) begin done_n++; done_edge = edge_n; end
            if (fill_err)  begin err_n++;  err_edge  = edge_n; end
            if (busy_d && !fill_busy) idle_edge = edge_n;
            busy_d = fill_busy;
        end
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_fill(input logic [31:0] adr);
        @(negedge clk);
        fill_req = 1'b1;
        fill_adr = adr;
        @(negedge clk);
        fill_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fill_busy && n < budget);
        chk({tag, "_idle"}, 32'(fill_busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_fill(input string tag, input logic [31:0] adr, input int start,
                              input int ab, input int vb, input int db, input int eb);
        logic [2:0]  ei;
        logic [31:0] ea;
        chk({tag, "_beats"}, idx_log.size() - vb, LW);
        chk({tag, "_acks"},  adr_log.size() - ab, LW);
        chk({tag, "_done"},  done_n - db, 1);
        chk({tag, "_err"},   err_n - eb, 0);
        for (int j = 0; j < LW; j++) begin
            ei = 3'((start + j) % LW);
            ea = {adr[31:5], ei, 2'b00};
            if (ab + j < adr_log.size())
                chk($sformatf("%s_adr%0d", tag, j), adr_log[ab + j], ea);
            if (vb + j < idx_log.size()) begin
                chk($sformatf("%s_idx%0d", tag, j), 32'(idx_log[vb + j]), 32'(ei));
                chk($sformatf("%s_dat%0d", tag, j), dat_log[vb + j], word_of(ea));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench did not finish");
    end

    initial begin : main
        int ab, vb, db, eb, n, k;
        fill_req   = 1'b0;
        fill_abort = 1'b0;
        fill_adr   = 32'h0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_ctrl", 32'({fill_busy, fill_vld, fill_done, fill_err, m_cyc, m_stb, m_we}), 32'd0);
        chk("rst_adr", m_adr, 32'd0);
        chk("rst_sel", 32'(m_sel), 32'hF);
        rst_n = 1'b1;

        // Reset asserted mid-fill clears outputs immediately.
        ack_lat = 2;
        start_fill(32'h3800_0640);
        repeat (2) @(negedge clk);
        chk("mid_cyc", 32'(m_cyc), 32'd1);
        chk("mid_vld_dat", fill_dat, word_of(32'h3800_0640));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", 32'({fill_busy, fill_vld, fill_done, fill_err, m_cyc, m_stb, m_we}), 32'd0);
        chk("mid_rst_adr", m_adr, 32'd0);
        chk("mid_rst_dat", fill_dat, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(fill_busy), 32'd0);
        chk("post_rst_cyc", 32'(m_cyc), 32'd0);

        // Zero-wait slave, in-order line. Counting the request cycle as
        // cycle 1: done pulses in cycle 17 (15 edges after the accepting
        // edge) and the engine is idle in cycle 18 = 2*LW+2.
        ack_lat = 1;
        ab = adr_log.size(); vb = idx_log.size(); db = done_n; eb = err_n;
        start_fill(32'h3800_0640);
        wait_idle("seq", 100);
        check_fill("seq", 32'h3800_0640, 0, ab, vb, db, eb);
        chk("seq_done_lat", done_edge - req_edge, 15);
        chk("seq_idle_lat", idle_edge - req_edge, 16);

        // Requested word 5: critical-word-first wraps 5,6,7,0..4.
        ab = adr_log.size(); vb = idx_log.size(); db = done_n; eb = err_n;
        start_fill(32'h3800_0614);
        wait_idle("cwf", 100);
        check_fill("cwf", 32'h3800_0614, CWF ? 5 : 0, ab, vb, db, eb);

        // Last word of the line requested, 3-cycle ack (below the watchdog).
        ack_lat = 3;
        ab = adr_log.size(); vb = idx_log.size(); db = done_n; eb = err_n;
        start_fill(32'h3800_07FC);
        wait_idle("slow", 200);
        check_fill("slow", 32'h3800_07FC, CWF ? 7 : 0, ab, vb, db, eb);

        // Requests pulsed while busy are ignored.
        ack_lat = 2;
        ab = adr_log.size(); vb = idx_log.size(); db = done_n; eb = err_n;
        start_fill(32'h3800_0640);
        repeat (3) begin
            @(negedge clk);
            fill_req = 1'b1;
            fill_adr = 32'h1234_567C;
            @(negedge clk);
            fill_req = 1'b0;
        end
        wait_idle("busyreq", 200);
        check_fill("busyreq", 32'h3800_0640, 0, ab, vb, db, eb);

        // Abort after the third word with a 3-cycle slave.
        ack_lat = 3;
        vb = idx_log.size(); db = done_n; eb = err_n;
        start_fill(32'h3800_0640);
        n = 0; k = 0;
        while (n < 3 && k < 100) begin
            @(negedge clk);
            k++;
            if (fill_vld) n++;
        end
        chk("abort_wait", n, 3);
        fill_abort = 1'b1;
        @(negedge clk);
        fill_abort = 1'b0;
        chk("abort_cyc", 32'(m_cyc), 32'd0);
        chk("abort_busy", 32'(fill_busy), 32'd0);
        repeat (10) @(negedge clk);
        chk("abort_vld_cnt", idx_log.size() - vb, 3);
        chk("abort_done", done_n - db, 0);
        chk("abort_err", err_n - eb, 0);

        // Abort in the same cycle as the first ack: word is dropped.
        ack_lat = 1;
        vb = idx_log.size(); db = done_n;
        start_fill(32'h3800_0640);
        fill_abort = 1'b1;
        @(negedge clk);
        fill_abort = 1'b0;
        chk("abort_ack_cyc", 32'(m_cyc), 32'd0);
        repeat (5) @(negedge clk);
        chk("abort_ack_vld", idx_log.size() - vb, 0);
        chk("abort_ack_done", done_n - db, 0);

        // Slave never acks: 4 strobe cycles, done+err in the 5th.
        ack_en = 1'b0;
        vb = idx_log.size(); db = done_n; eb = err_n;
        start_fill(32'h3800_0640);
        wait_idle("tmo", 50);
        chk("tmo_done", done_n - db, 1);
        chk("tmo_err", err_n - eb, 1);
        chk("tmo_done_lat", done_edge - req_edge, 4);
        chk("tmo_err_lat", err_edge - req_edge, 4);
        chk("tmo_vld", idx_log.size() - vb, 0);
        chk("tmo_cyc", 32'(m_cyc), 32'd0);
        ack_en = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
